// File: rtl/ws2812_receiver.sv
// WS2812 one-wire decoder: captures the first 24 bits (GRB, MSB first) per frame; forwarding under WS2812_RX_FORWARD_EN.
// Latency: valid/r/g/b/err 3 clk after din falls; frame_end 1 clk after the latch low count is hit; dout 3 clk after din.
// Backpressure: none; din is a free-running line and every status output is a single-cycle pulse.
module ws2812_receiver #(
  parameter int HIGH_MIN   = 2,
  parameter int BIT_THRESH = 6,
  parameter int HIGH_MAX   = 12,
  parameter int RESET_LOW  = 500,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       valid,
  output logic       frame_end,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {WAIT_RESET, IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HMIN = CNT_W'(HIGH_MIN);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] HSAT = CNT_W'(HIGH_MAX + 1);
  localparam logic [CNT_W-1:0] BTH  = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] RLOW = CNT_W'(RESET_LOW);

  state_t           state;
  logic             ds_meta;
  logic             ds;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] low_inc;
  logic [4:0]       idx;
  logic             captured;
  logic [22:0]      shreg;
  logic             bit_val;
  logic [23:0]      shift_in;
  logic             pulse_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_meta <= 1'b0;
      ds      <= 1'b0;
    end else begin
      ds_meta <= din;
      ds      <= ds_meta;
    end
  end

  assign low_inc   = (low_cnt == '1) ? low_cnt : low_cnt + ONE;
  assign bit_val   = (high_cnt >= BTH);
  assign shift_in  = {shreg, bit_val};
  assign pulse_bad = (high_cnt < HMIN) || (high_cnt > HMAX);

  // IDLE and LOW are only ever entered on a cycle with ds low, so ds high there is a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_RESET;
      high_cnt  <= '0;
      low_cnt   <= '0;
      idx       <= '0;
      captured  <= 1'b0;
      shreg     <= '0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      valid     <= 1'b0;
      frame_end <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_end <= 1'b0;
      err       <= 1'b0;
      case (state)
        WAIT_RESET: begin
          if (ds) begin
            low_cnt <= '0;
          end else begin
            low_cnt <= low_inc;
            if (low_inc >= RLOW) state <= IDLE;
          end
        end
        IDLE: begin
          if (ds) begin
            state    <= HIGH;
            high_cnt <= ONE;
            busy     <= 1'b1;
          end
        end
        HIGH: begin
          if (ds) begin
            if (high_cnt < HSAT) high_cnt <= high_cnt + ONE;
          end else begin
            state   <= LOW;
            low_cnt <= ONE;
            if (pulse_bad) begin
              err <= 1'b1;
            end else if (!captured) begin
              shreg <= shift_in[22:0];
              if (idx == 5'd23) begin
                g        <= shift_in[23:16];
                r        <= shift_in[15:8];
                b        <= shift_in[7:0];
                valid    <= 1'b1;
                captured <= 1'b1;
                idx      <= 5'd24;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
        end
        LOW: begin
          if (ds) begin
            state    <= HIGH;
            high_cnt <= ONE;
          end else begin
            low_cnt <= low_inc;
            if (low_inc >= RLOW) begin
              // A latch after 1..23 stored bits means the frame was cut short.
              frame_end <= 1'b1;
              err       <= (idx != 5'd0) && (idx < 5'd24);
              idx       <= '0;
              captured  <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= WAIT_RESET;
      endcase
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b0;
    end else begin
      dout <= captured && ((state == HIGH) || (state == LOW)) && ds;
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_receiver.sv
// Bench for ws2812_receiver: randomized frames checked against a pulse-list reference model.
// Latency: checks valid at din fall + 3 clk and forwarded edges at din + 3 clk.
// Backpressure: n/a; stimulus is a timed pulse train.
`timescale 1ns/1ps
module tb_ws2812_receiver;
  localparam int HIGH_MIN   = 2;
  localparam int BIT_THRESH = 6;
  localparam int HIGH_MAX   = 12;
  localparam int RESET_LOW  = 500;
  localparam int CNT_W      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       dout, valid, frame_end, err, busy;
  logic [7:0] r, g, b;

  ws2812_receiver #(
    .HIGH_MIN(HIGH_MIN), .BIT_THRESH(BIT_THRESH), .HIGH_MAX(HIGH_MAX),
    .RESET_LOW(RESET_LOW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .r(r), .g(g), .b(b),
    .valid(valid), .frame_end(frame_end), .err(err), .busy(busy)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  // Monitor: counts pulses and records forwarded dout pulses.
  int         n_valid, n_fe, n_err, n_fe_err, valid_cyc, dout_run;
  logic       dout_prev = 1'b0;
  int         dout_rise_q[$];
  int         dout_w_q[$];

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (frame_end) n_fe++;
    if (err) n_err++;
    if (frame_end && err) n_fe_err++;
    if (dout && !dout_prev) begin
      dout_rise_q.push_back(cyc);
      dout_run = 0;
    end
    if (dout) dout_run++;
    if (!dout && dout_prev) dout_w_q.push_back(dout_run);
    dout_prev = dout;
  end

  int         frame_w[$];
  int         frame_lo[$];
  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] exp_r = 8'h00, exp_g = 8'h00, exp_b = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_valid = 0; n_fe = 0; n_err = 0; n_fe_err = 0; valid_cyc = -1;
    dout_rise_q.delete();
    dout_w_q.delete();
  endtask

  // mode 0: random widths per bit class, 1: 4/8-cycle highs at 12-cycle period, 2: 5/6-cycle highs.
  task automatic add_bits(input logic [23:0] word, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      bit bv;
      int w;
      bv = word[23-i];
      case (mode)
        1:       w = bv ? 8 : 4;
        2:       w = bv ? 6 : 5;
        default: w = bv ? int'($urandom_range(12, 6)) : int'($urandom_range(5, 2));
      endcase
      frame_w.push_back(w);
      frame_lo.push_back((mode == 1) ? 12 - w : int'($urandom_range(10, 3)));
    end
  endtask

  task automatic new_frame();
    frame_w.delete();
    frame_lo.delete();
  endtask

  task automatic drive_frame();
    rise_q.delete();
    fall_q.delete();
    foreach (frame_w[i]) begin
      din = 1'b1;
      rise_q.push_back(cyc);
      repeat (frame_w[i]) @(posedge clk);
      #1 din = 1'b0;
      fall_q.push_back(cyc);
      repeat (frame_lo[i]) @(posedge clk);
      #1;
    end
  endtask

  // Reference: classify each pulse width, take the first 24 good bits, forward every pulse after them.
  task automatic run_frame(input string tag, input bit latch, input bit synced);
    int          nb, ne, fwd_from, fall24, k;
    logic [23:0] word;
    bit          partial;
    clear_mon();
    drive_frame();
    idle(latch ? 600 : 20);
    @(negedge clk);
    nb = 0; ne = 0; word = '0; fall24 = 0; fwd_from = frame_w.size();
    foreach (frame_w[i]) begin
      if (frame_w[i] < HIGH_MIN || frame_w[i] > HIGH_MAX) begin
        ne++;
      end else begin
        if (nb < 24) word[23-nb] = (frame_w[i] >= BIT_THRESH);
        nb++;
        if (nb == 24) begin
          fall24   = fall_q[i];
          fwd_from = i + 1;
        end
      end
    end
`ifndef WS2812_RX_FORWARD_EN
    fwd_from = frame_w.size();
`endif
    if (!synced) begin
      nb = 0; ne = 0; fwd_from = frame_w.size();
    end
    partial = latch && synced && (nb > 0) && (nb < 24);
    check({tag, "/valid_cnt"}, n_valid, (nb >= 24) ? 1 : 0);
    if (nb >= 24) begin
      {exp_g, exp_r, exp_b} = word;
      check({tag, "/valid_lat"}, valid_cyc, fall24 + 3);
    end
    check({tag, "/err_cnt"}, n_err, ne + int'(partial));
    check({tag, "/fe_cnt"}, n_fe, (latch && synced) ? 1 : 0);
    check({tag, "/fe_err"}, n_fe_err, int'(partial));
    check({tag, "/rgb"}, {8'h00, r, g, b}, {8'h00, exp_r, exp_g, exp_b});
    check({tag, "/busy_end"}, busy, latch ? 0 : (synced ? 1 : 0));
    check({tag, "/fwd_cnt"}, dout_rise_q.size(), frame_w.size() - fwd_from);
    for (int i = fwd_from; i < frame_w.size(); i++) begin
      k = i - fwd_from;
      if (k < dout_rise_q.size()) check({tag, "/fwd_rise"}, dout_rise_q[k], rise_q[i] + 3);
      if (k < dout_w_q.size()) check({tag, "/fwd_width"}, dout_w_q[k], frame_w[i]);
    end
    realign();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {8'h00, r, g, b}, 32'h0);
    check("reset_flags", {valid, frame_end, err, busy, dout}, 5'b0);
    realign();
    rst = 1'b0;
    clear_mon();
    idle(600);
    @(negedge clk);
    check("wait_reset_no_fe", n_fe, 0);
    check("wait_reset_busy", busy, 0);
    realign();

    new_frame();
    add_bits(24'h00FF0F, 24, 1);
    run_frame("plan", 1'b1, 1'b1);
    check("plan_r", r, 8'hFF);
    check("plan_g", g, 8'h00);
    check("plan_b", b, 8'h0F);

    new_frame();
    add_bits(24'($urandom), 24, 2);
    run_frame("thresh", 1'b1, 1'b1);

    for (int n = 0; n < 3; n++) begin
      new_frame();
      add_bits(24'($urandom), 24, 0);
      run_frame("random", 1'b1, 1'b1);
    end

    begin
      logic [23:0] w;
      w = 24'($urandom);
      new_frame();
      add_bits(w, 5, 0);
      frame_w.push_back(1);  frame_lo.push_back(6);
      add_bits(w << 5, 10, 0);
      frame_w.push_back(14); frame_lo.push_back(6);
      add_bits(w << 15, 9, 0);
      run_frame("bad_pulse", 1'b1, 1'b1);
    end

    new_frame();
    add_bits(24'($urandom), 10, 0);
    run_frame("partial", 1'b1, 1'b1);

    new_frame();
    add_bits(24'($urandom), 24, 0);
    add_bits(24'($urandom), 24, 0);
    run_frame("bits48", 1'b1, 1'b1);

    new_frame();
    add_bits(24'($urandom), 12, 0);
    clear_mon();
    drive_frame();
    @(negedge clk);
    check("mid_busy", busy, 1);
    realign();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_clear", {8'h00, r, g, b}, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_no_err", n_err, 0);
    {exp_r, exp_g, exp_b} = 24'h0;
    realign();
    new_frame();
    add_bits(24'($urandom), 24, 0);
    run_frame("after_rst", 1'b0, 1'b0);
    idle(600);
    @(negedge clk);
    check("after_rst_no_valid", n_valid, 0);
    check("after_rst_no_fe", n_fe, 0);
    realign();

    new_frame();
    add_bits(24'($urandom), 24, 0);
    run_frame("resync", 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
